hazard_ctl: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS core. Watches the ID, EX and MEM stages and drives the write-enable, bubble and flush controls of the PC, IF/ID, ID/EX and EX/MEM pipeline registers. It handles three cases: load-use stalls, taken-branch flushes, and multi-cycle mult/div occupancy of EX. Sits beside the decode stage and is instantiated once in the core top level.

---
 rtl/hazard_ctl.sv | 109 ++++++++++
 tb/tb_hazard_ctl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/hazard_ctl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and mult/div EX occupancy.
// Optional stall-cycle performance counter enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctl #(
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       ID_muldiv,
  input  logic       EX_memread,
  input  logic [4:0] EX_rt,
  input  logic       MEM_pcsrc,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic       idex_write,
  output logic       idex_bubble,
  output logic       exmem_bubble,
  output logic       muldiv_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic {
    RUN    = 1'b0,
    MULDIV = 1'b1
  } state_t;

  localparam logic [3:0] CNT_LOAD     = 4'(MULDIV_CYCLES - 1);
  localparam bit         MULDIV_MULTI = (MULDIV_CYCLES > 1);

  state_t     state, next_state;
  logic [3:0] cnt, next_cnt;
  logic       load_use;

  assign load_use = EX_memread && (EX_rt != 5'd0) &&
                    ((EX_rt == ID_rs) || (EX_rt == ID_rt));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  always_comb begin
    next_state   = state;
    next_cnt     = cnt;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    muldiv_busy  = (state == MULDIV);

    if (reset) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_bubble = 1'b1;
      muldiv_busy  = 1'b0;
      next_state   = RUN;
      next_cnt     = '0;
    end else if (MEM_pcsrc) begin
      // The branch is older than any mult/div in EX, so the mult/div is squashed too.
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_bubble = 1'b1;
      next_state   = RUN;
      next_cnt     = '0;
    end else if (state == MULDIV) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_bubble = 1'b1;
      next_cnt     = cnt - 4'd1;
      if (cnt <= 4'd1) begin
        next_state = RUN;
        next_cnt   = '0;
      end
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (ID_muldiv && MULDIV_MULTI) begin
      next_state = MULDIV;
      next_cnt   = CNT_LOAD;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (!pc_write && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctl.sv
// Scoreboard bench for hazard_ctl: directed scenarios followed by random stimulus,
// checked against a cycle-count reference model.
module tb_hazard_ctl;

  localparam int unsigned MC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] ID_rs = '0;
  logic [4:0] ID_rt = '0;
  logic       ID_muldiv = 1'b0;
  logic       EX_memread = 1'b0;
  logic [4:0] EX_rt = '0;
  logic       MEM_pcsrc = 1'b0;
  logic       pc_write, ifid_write, ifid_flush, idex_write;
  logic       idex_bubble, exmem_bubble, muldiv_busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt;
`endif

  hazard_ctl #(.MULDIV_CYCLES(MC)) dut (
    .clk         (clk),
    .reset       (reset),
    .ID_rs       (ID_rs),
    .ID_rt       (ID_rt),
    .ID_muldiv   (ID_muldiv),
    .EX_memread  (EX_memread),
    .EX_rt       (EX_rt),
    .MEM_pcsrc   (MEM_pcsrc),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write),
    .ifid_flush  (ifid_flush),
    .idex_write  (idex_write),
    .idex_bubble (idex_bubble),
    .exmem_bubble(exmem_bubble),
    .muldiv_busy (muldiv_busy)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ctl = {pc_write, ifid_write, idex_write, ifid_flush, idex_bubble, exmem_bubble, muldiv_busy}
  typedef struct {
    logic [6:0] ctl;
    int         sc;
    bit         sc_known;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  // Reference model state: cycles of EX occupancy still owed, and stalls seen.
  int   rem = 0;
  int   sc = 0;
  bit   sc_known = 1'b0;
  int   cyc = 0;

  task automatic check(input string name, input int c, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d got %h expected %h", name, c, got, exp);
  endtask

  task automatic step(input bit r, input bit pcs, input bit md, input bit mr,
                      input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt);
    exp_t e;
    bit   lu;
    logic [6:0] ctl;
    int   nrem;
    @(posedge clk);
    #1;
    reset = r; MEM_pcsrc = pcs; ID_muldiv = md; EX_memread = mr;
    EX_rt = ert; ID_rs = rs; ID_rt = rt;
    lu = mr && (ert != 0) && (ert == rs || ert == rt);
    nrem = 0;
    if (r)             ctl = 7'b0011110;
    else if (pcs)      ctl = {6'b111111, rem > 0};
    else if (rem > 0) begin
      ctl  = 7'b0000011;
      nrem = rem - 1;
    end else if (lu)   ctl = 7'b0010100;
    else begin
      ctl = 7'b1110000;
      if (md) nrem = int'(MC) - 1;
    end
    e.ctl = ctl; e.sc = sc; e.sc_known = sc_known; e.cyc = cyc;
    q.push_back(e);
    if (r) begin
      sc = 0;
      sc_known = 1'b1;
    end else if (!ctl[6] && sc < 65535) sc++;
    rem = nrem;
    cyc++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("ctl", e.cyc,
              {25'd0, pc_write, ifid_write, idex_write, ifid_flush, idex_bubble,
               exmem_bubble, muldiv_busy},
              {25'd0, e.ctl});
`ifdef HAZARD_PERF_CNT_EN
        if (e.sc_known) check("stall_cnt", e.cyc, {16'd0, stall_cnt}, e.sc);
`endif
      end
    end
  end

  initial begin : driver
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    // load-use then release
    step(0, 0, 0, 1, 8, 8, 3);
    step(0, 0, 0, 0, 8, 8, 3);
    // load to $zero
    step(0, 0, 0, 1, 0, 9, 0);
    // mult/div occupies EX for MC-1 cycles
    step(0, 0, 1, 0, 0, 1, 2);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, 2);
    // branch in first MULDIV cycle
    step(0, 0, 1, 0, 0, 1, 2);
    step(0, 1, 0, 0, 0, 1, 2);
    step(0, 0, 0, 0, 0, 1, 2);
    // simultaneous hazards
    step(0, 1, 1, 1, 8, 8, 0);
    step(0, 0, 1, 1, 8, 8, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // reset on second MULDIV cycle
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // five load-use stalls
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1, 7, 1, 7);
      step(0, 0, 0, 0, 7, 1, 7);
    end
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    end
    repeat (3) @(posedge clk);
    check("drain", cyc, q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
